// File: rtl/sdram_arb.sv
// Shares one SDRAM controller between refresh, the init loader, ROM download and the CPU.
// Fixed priority, one command in flight, each command occupies OP_CYCLES clocks.
module sdram_arb #(
  parameter int OP_CYCLES   = 8,
  parameter int RD_LAT      = 6,
  parameter int RFSH_PERIOD = 500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ready,
  input  logic        iniReq,
  input  logic        iniWr,
  input  logic [21:0] iniA,
  input  logic [7:0]  iniD,
  input  logic        dlReq,
  input  logic [21:0] dlA,
  input  logic [7:0]  dlD,
  input  logic        cpuRd,
  input  logic        cpuWr,
  input  logic [21:0] cpuA,
  input  logic [7:0]  cpuD,
  output logic        iniAck,
  output logic        dlAck,
  output logic        cpuAck,
  output logic [7:0]  cpuQ,
  output logic        sdRf,
  output logic        sdRd,
  output logic        sdWr,
  output logic [23:0] sdA,
  output logic [15:0] sdD,
  input  logic [15:0] sdQ,
  output logic        overrun,
  output logic        dbgBusy
);
  localparam int CW = $clog2(OP_CYCLES + 1);
  localparam int RW = $clog2(RFSH_PERIOD + 1);

  typedef enum logic { IDLE, BUSY } state_t;
  typedef enum logic [1:0] { G_RF, G_INI, G_DL, G_CPU } grant_t;

  state_t        state, stateNext;
  grant_t        grant, grantNext;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rfCnt;
  logic          rfPend, iniPend, dlPend, cpuPend;
  logic          iniWrR, cpuWrR;
  logic [21:0]   iniAR, dlAR, cpuAR;
  logic [7:0]    iniDR, dlDR, cpuDR;
  logic          start, done;
  logic          rfDone, iniDone, dlDone, cpuDone;
  logic          cpuReq;
  logic [7:0]    unusedSdQHi;

  assign unusedSdQHi = sdQ[15:8];
  assign cpuReq  = cpuRd | cpuWr;
  assign dbgBusy = (state == BUSY);
  assign rfDone  = done && (grant == G_RF);
  assign iniDone = done && (grant == G_INI);
  assign dlDone  = done && (grant == G_DL);
  assign cpuDone = done && (grant == G_CPU);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      grant <= G_RF;
    end else begin
      state <= stateNext;
      grant <= grantNext;
    end
  end

  always_comb begin
    stateNext = state;
    grantNext = grant;
    start     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (ready && (rfPend || iniPend || dlPend || cpuPend)) begin
        start     = 1'b1;
        stateNext = BUSY;
        if (rfPend)       grantNext = G_RF;
        else if (iniPend) grantNext = G_INI;
        else if (dlPend)  grantNext = G_DL;
        else              grantNext = G_CPU;
      end
      BUSY: if (cnt == CW'(OP_CYCLES - 1)) begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      rfCnt   <= RW'(RFSH_PERIOD - 1);
      rfPend  <= 1'b0;
      iniPend <= 1'b0;
      dlPend  <= 1'b0;
      cpuPend <= 1'b0;
      iniWrR  <= 1'b0;
      cpuWrR  <= 1'b0;
      iniAR   <= '0;
      dlAR    <= '0;
      cpuAR   <= '0;
      iniDR   <= '0;
      dlDR    <= '0;
      cpuDR   <= '0;
      iniAck  <= 1'b0;
      dlAck   <= 1'b0;
      cpuAck  <= 1'b0;
      cpuQ    <= '0;
      sdRf    <= 1'b0;
      sdRd    <= 1'b0;
      sdWr    <= 1'b0;
      sdA     <= '0;
      sdD     <= '0;
      overrun <= 1'b0;
    end else begin
      if (start || done) cnt <= '0;
      else if (state == BUSY) cnt <= cnt + CW'(1);

      iniAck <= iniDone;
      dlAck  <= dlDone;
      cpuAck <= cpuDone;

      // Command strobes live for exactly the cycle after the grant edge.
      sdRf <= 1'b0;
      sdRd <= 1'b0;
      sdWr <= 1'b0;
      sdA  <= '0;
      sdD  <= '0;
      if (start) begin
        case (grantNext)
          G_RF: sdRf <= 1'b1;
          G_INI: begin
            sdRd <= !iniWrR;
            sdWr <= iniWrR;
            sdA  <= {2'b00, iniAR};
            sdD  <= iniWrR ? {8'h00, iniDR} : 16'h0000;
          end
          G_DL: begin
            sdWr <= 1'b1;
            sdA  <= {2'b00, dlAR};
            sdD  <= {8'h00, dlDR};
          end
          default: begin
            sdRd <= !cpuWrR;
            sdWr <= cpuWrR;
            sdA  <= {2'b00, cpuAR};
            sdD  <= cpuWrR ? {8'h00, cpuDR} : 16'h0000;
          end
        endcase
      end

      if (state == BUSY && grant == G_CPU && !cpuWrR && cnt == CW'(RD_LAT - 1))
        cpuQ <= sdQ[7:0];

      // A refresh falling due on its own completion edge stays pending.
      if (rfDone) rfPend <= 1'b0;
      if (rfCnt == '0) begin
        rfCnt  <= RW'(RFSH_PERIOD - 1);
        rfPend <= 1'b1;
      end else begin
        rfCnt <= rfCnt - RW'(1);
      end

      if (iniDone) iniPend <= 1'b0;
      if (iniReq) begin
        if (iniPend && !iniDone) overrun <= 1'b1;
        else begin
          iniPend <= 1'b1;
          iniWrR  <= iniWr;
          iniAR   <= iniA;
          iniDR   <= iniD;
        end
      end

      if (dlDone) dlPend <= 1'b0;
      if (dlReq) begin
        if (dlPend && !dlDone) overrun <= 1'b1;
        else begin
          dlPend <= 1'b1;
          dlAR   <= dlA;
          dlDR   <= dlD;
        end
      end

      if (cpuDone) cpuPend <= 1'b0;
      if (cpuReq) begin
        if (cpuPend && !cpuDone) overrun <= 1'b1;
        else begin
          cpuPend <= 1'b1;
          cpuWrR  <= cpuWr;
          cpuAR   <= cpuA;
          cpuDR   <= cpuD;
        end
      end
    end
  end
endmodule

// File: tb/tb_sdram_arb.sv
// Bench for sdram_arb: directed scenarios plus randomized traffic against a
// timestamp-based reference model of the arbiter.
module tb_sdram_arb;
  localparam int OP = 8;
  localparam int RL = 6;
  localparam int RP = 500;

  logic        clock = 1'b0;
  logic        reset, ready;
  logic        iniReq, iniWr, dlReq, cpuRd, cpuWr;
  logic [21:0] iniA, dlA, cpuA;
  logic [7:0]  iniD, dlD, cpuD;
  logic        iniAck, dlAck, cpuAck;
  logic [7:0]  cpuQ;
  logic        sdRf, sdRd, sdWr;
  logic [23:0] sdA;
  logic [15:0] sdD, sdQ;
  logic        overrun, dbgBusy;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  sdram_arb #(.OP_CYCLES(OP), .RD_LAT(RL), .RFSH_PERIOD(RP)) dut (
    .clock(clock), .reset(reset), .ready(ready),
    .iniReq(iniReq), .iniWr(iniWr), .iniA(iniA), .iniD(iniD),
    .dlReq(dlReq), .dlA(dlA), .dlD(dlD),
    .cpuRd(cpuRd), .cpuWr(cpuWr), .cpuA(cpuA), .cpuD(cpuD),
    .iniAck(iniAck), .dlAck(dlAck), .cpuAck(cpuAck), .cpuQ(cpuQ),
    .sdRf(sdRf), .sdRd(sdRd), .sdWr(sdWr), .sdA(sdA), .sdD(sdD), .sdQ(sdQ),
    .overrun(overrun), .dbgBusy(dbgBusy)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    iniReq = 1'b0; iniWr = 1'b1; iniA = '0; iniD = '0;
    dlReq = 1'b0; dlA = '0; dlD = '0;
    cpuRd = 1'b0; cpuWr = 1'b0; cpuA = '0; cpuD = '0;
    sdQ = 16'h5A5A;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int nStb;
    clear_inputs();
    reset = 1'b1; ready = 1'b1;
    iniReq = 1'b1; dlReq = 1'b1; cpuRd = 1'b1; cpuA = 22'h3ABCDE;
    step();
    step();
    reset = 1'b0;
    clear_inputs();
    total++;
    if ({iniAck, dlAck, cpuAck, cpuQ, sdRf, sdRd, sdWr, sdA, sdD, overrun, dbgBusy} !== 62'd0)
      $display("FAIL reset_outputs: got %h required 0",
               {iniAck, dlAck, cpuAck, cpuQ, sdRf, sdRd, sdWr, sdA, sdD, overrun, dbgBusy});
    else passed++;
    nStb = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (sdRf || sdRd || sdWr) nStb++;
    end
    total++;
    if (nStb != 0) $display("FAIL reset_discards_strobes: strobes=%0d required 0", nStb);
    else passed++;
  endtask

  task automatic test_ready_read();
    int nStb;
    apply_reset();
    ready = 1'b0;
    cpuRd = 1'b1; cpuA = 22'h012345;
    step();
    cpuRd = 1'b0; cpuA = 22'h2AAAAA;
    nStb = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (sdRf || sdRd || sdWr) nStb++;
    end
    total++;
    if (nStb != 0) $display("FAIL ready_low_blocks: strobes=%0d required 0", nStb);
    else passed++;
    ready = 1'b1;
    step();
    total++;
    if ({sdRf, sdRd, sdWr, sdA} !== {3'b010, 24'h012345})
      $display("FAIL ready_read_strobe: rf/rd/wr/A=%b%b%b %h required 010 012345", sdRf, sdRd, sdWr, sdA);
    else passed++;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) begin
        total++;
        if ({sdRd, sdA, sdD} !== 41'd0)
          $display("FAIL ready_read_one_cycle: rd=%b A=%h D=%h required 0", sdRd, sdA, sdD);
        else passed++;
      end
      total++;
      if (cpuAck !== 1'(k == OP))
        $display("FAIL ready_read_ack k=%0d: cpuAck=%b required %b", k, cpuAck, (k == OP));
      else passed++;
      if (k == OP) begin
        total++;
        if (cpuQ !== 8'hC3) $display("FAIL ready_read_data: cpuQ=%h required c3", cpuQ);
        else passed++;
      end
      sdQ = (k == RL - 1) ? 16'h00C3 : 16'h5A5A;
    end
  endtask

  task automatic test_priority();
    logic [21:0] iA, dA, cA;
    logic [7:0]  iD, dD;
    logic [45:0] expV, actV;
    apply_reset();
    ready = 1'b1;
    iA = 22'($urandom); dA = 22'($urandom); cA = 22'($urandom);
    iD = 8'($urandom);  dD = 8'($urandom);
    iniReq = 1'b1; iniWr = 1'b1; iniA = iA; iniD = iD;
    dlReq = 1'b1; dlA = dA; dlD = dD;
    cpuWr = 1'b1; cpuA = cA; cpuD = 8'hA5;
    step();
    iniReq = 1'b0; dlReq = 1'b0; cpuWr = 1'b0;
    iniA = 22'($urandom); dlA = 22'($urandom); cpuA = 22'($urandom);
    iniD = 8'($urandom); dlD = 8'($urandom); cpuD = 8'($urandom);
    for (int k = 1; k <= 30; k++) begin
      step();
      expV = '0;
      case (k)
        1:  expV = {3'b001, 2'b00, iA, 8'h00, iD, 3'b000};
        10: expV = {3'b001, 2'b00, dA, 8'h00, dD, 3'b000};
        19: expV = {3'b001, 2'b00, cA, 16'h00A5, 3'b000};
        9:  expV = {43'd0, 3'b100};
        18: expV = {43'd0, 3'b010};
        27: expV = {43'd0, 3'b001};
        default: expV = '0;
      endcase
      actV = {sdRf, sdRd, sdWr, sdA, sdD, iniAck, dlAck, cpuAck};
      total++;
      if (actV !== expV) $display("FAIL priority k=%0d: got %h required %h", k, actV, expV);
      else passed++;
    end
  endtask

  task automatic test_refresh();
    int evq[$];
    int expq[$];
    logic [23:0] rdA;
    logic [21:0] cA;
    apply_reset();
    ready = 1'b1;
    cA = 22'($urandom);
    rdA = '1;
    expq = '{(RP + 1) * 4 + 1, (2 * RP + 1) * 4 + 1, (3 * RP + 1) * 4 + 1, (3 * RP + OP + 2) * 4 + 2};
    for (int k = 1; k <= 3 * RP + 30; k++) begin
      step();
      if (sdRf) evq.push_back(k * 4 + 1);
      if (sdRd) begin evq.push_back(k * 4 + 2); rdA = sdA; end
      if (sdWr) evq.push_back(k * 4 + 3);
      if (sdRf && (sdA !== 24'd0)) begin
        total++;
        $display("FAIL refresh_addr k=%0d: sdA=%h required 0", k, sdA);
      end
      cpuRd = (k == 3 * RP - 1);
      cpuA  = (k == 3 * RP - 1) ? cA : 22'($urandom);
    end
    total++;
    if (evq.size() != expq.size()) $display("FAIL refresh_count: events=%0d required %0d", evq.size(), expq.size());
    else passed++;
    foreach (expq[i]) begin
      total++;
      if (i >= evq.size()) $display("FAIL refresh_event%0d: missing, required cycle %0d kind %0d", i, expq[i] / 4, expq[i] % 4);
      else if (evq[i] != expq[i])
        $display("FAIL refresh_event%0d: cycle %0d kind %0d required cycle %0d kind %0d",
                 i, evq[i] / 4, evq[i] % 4, expq[i] / 4, expq[i] % 4);
      else passed++;
    end
    total++;
    if (rdA !== {2'b00, cA}) $display("FAIL refresh_then_read_addr: sdA=%h required %h", rdA, {2'b00, cA});
    else passed++;
  endtask

  task automatic test_overrun();
    logic [21:0] a1, a2;
    logic [23:0] firstA;
    int nRd, nAck, ovLow;
    apply_reset();
    ready = 1'b0;
    a1 = 22'($urandom); a2 = a1 ^ 22'h15A5A5;
    cpuRd = 1'b1; cpuA = a1;
    step();
    cpuRd = 1'b0; cpuA = 22'($urandom);
    step();
    step();
    total++;
    if (overrun !== 1'b0) $display("FAIL overrun_before: overrun=%b required 0", overrun);
    else passed++;
    cpuRd = 1'b1; cpuA = a2;
    step();
    cpuRd = 1'b0;
    total++;
    if (overrun !== 1'b1) $display("FAIL overrun_set: overrun=%b required 1", overrun);
    else passed++;
    ready = 1'b1;
    nRd = 0; nAck = 0; ovLow = 0; firstA = '0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (sdRd) begin if (nRd == 0) firstA = sdA; nRd++; end
      if (cpuAck) nAck++;
      if (overrun !== 1'b1) ovLow++;
    end
    total++;
    if (nRd != 1) $display("FAIL overrun_single_read: reads=%0d required 1", nRd);
    else passed++;
    total++;
    if (firstA !== {2'b00, a1}) $display("FAIL overrun_first_addr: sdA=%h required %h", firstA, {2'b00, a1});
    else passed++;
    total++;
    if (nAck != 1) $display("FAIL overrun_single_ack: acks=%0d required 1", nAck);
    else passed++;
    total++;
    if (ovLow != 0) $display("FAIL overrun_sticky: cycles low=%0d required 0", ovLow);
    else passed++;
    apply_reset();
    total++;
    if (overrun !== 1'b0) $display("FAIL overrun_reset: overrun=%b required 0", overrun);
    else passed++;
  endtask

  task automatic test_reset_busy();
    int nEv;
    logic [21:0] cA;
    apply_reset();
    ready = 1'b1;
    dlReq = 1'b1; dlA = 22'($urandom); dlD = 8'($urandom);
    step();
    dlReq = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 1) begin
        total++;
        if (sdWr !== 1'b1) $display("FAIL reset_busy_grant: sdWr=%b required 1", sdWr);
        else passed++;
      end
    end
    reset = 1'b1; cpuRd = 1'b1; cpuA = 22'($urandom);
    step();
    reset = 1'b0; cpuRd = 1'b0;
    total++;
    if ({iniAck, dlAck, cpuAck, cpuQ, sdRf, sdRd, sdWr, sdA, sdD, overrun, dbgBusy} !== 62'd0)
      $display("FAIL reset_busy_outputs: got %h required 0",
               {iniAck, dlAck, cpuAck, cpuQ, sdRf, sdRd, sdWr, sdA, sdD, overrun, dbgBusy});
    else passed++;
    nEv = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (sdRf || sdRd || sdWr || iniAck || dlAck || cpuAck) nEv++;
    end
    total++;
    if (nEv != 0) $display("FAIL reset_busy_quiet: events=%0d required 0", nEv);
    else passed++;
    cA = 22'($urandom);
    cpuWr = 1'b1; cpuA = cA; cpuD = 8'h3C;
    step();
    cpuWr = 1'b0;
    step();
    total++;
    if ({sdWr, sdA, sdD} !== {1'b1, 2'b00, cA, 16'h003C})
      $display("FAIL reset_busy_new_request: wr/A/D=%b %h %h required 1 %h 003c", sdWr, sdA, sdD, {2'b00, cA});
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [21:0] a1, a2;
    logic [7:0]  q1, q2;
    apply_reset();
    ready = 1'b1;
    a1 = 22'($urandom); a2 = 22'($urandom);
    q1 = {1'b1, 7'($urandom)}; q2 = {1'b1, 7'($urandom)};
    cpuRd = 1'b1; cpuA = a1;
    step();
    cpuRd = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) begin
        total++;
        if ({sdRd, sdA} !== {1'b1, 2'b00, a1}) $display("FAIL b2b_first_read: rd/A=%b %h required 1 %h", sdRd, sdA, {2'b00, a1});
        else passed++;
      end
      if (k == OP + 1 || k == 2 * OP + 2) begin
        total++;
        if (cpuAck !== 1'b1) $display("FAIL b2b_ack k=%0d: cpuAck=%b required 1", k, cpuAck);
        else passed++;
        total++;
        if (cpuQ !== ((k == OP + 1) ? q1 : q2)) $display("FAIL b2b_data k=%0d: cpuQ=%h required %h", k, cpuQ, (k == OP + 1) ? q1 : q2);
        else passed++;
        total++;
        if (overrun !== 1'b0) $display("FAIL b2b_no_overrun k=%0d: overrun=%b required 0", k, overrun);
        else passed++;
      end
      if (k == OP + 2) begin
        total++;
        if ({sdRd, sdA, cpuAck} !== {1'b1, 2'b00, a2, 1'b0})
          $display("FAIL b2b_second_read: rd/A/ack=%b %h %b required 1 %h 0", sdRd, sdA, cpuAck, {2'b00, a2});
        else passed++;
      end
      cpuRd = (k == OP);
      cpuA  = (k == OP) ? a2 : 22'($urandom);
      if (k == RL) sdQ = {8'($urandom), q1};
      else if (k == OP + 1 + RL) sdQ = {8'($urandom), q2};
      else sdQ = 16'h5A5A;
    end
  endtask

  task automatic test_random(input int cycles, input int rate);
    bit          mPend[3];
    bit          mWr[3];
    logic [21:0] mA[3];
    logic [7:0]  mD[3];
    bit          req[3];
    bit          wr[3];
    logic [21:0] a[3];
    logic [7:0]  d[3];
    bit          eAck[3];
    bit          mRf, busyM, mOv, eRf, eRd, eWr, cpuHit;
    int          cur, doneAt, freeAt, sampleAt;
    logic [7:0]  mQ;
    logic [23:0] eA;
    logic [15:0] eD, actD;
    logic [54:0] expV, actV;
    apply_reset();
    mRf = 0; busyM = 0; mOv = 0; cur = 0; doneAt = 0; freeAt = 0; sampleAt = 0; mQ = '0;
    for (int i = 0; i < 3; i++) begin mPend[i] = 0; mWr[i] = 0; mA[i] = '0; mD[i] = '0; end
    for (int e = 1; e <= cycles; e++) begin
      ready  = (int'($urandom_range(0, 9)) != 0);
      iniReq = (int'($urandom_range(0, 199)) < rate);
      iniWr  = 1'b1; iniA = 22'($urandom); iniD = 8'($urandom);
      dlReq  = (int'($urandom_range(0, 149)) < rate);
      dlA    = 22'($urandom); dlD = 8'($urandom);
      cpuHit = (int'($urandom_range(0, 99)) < rate);
      cpuWr  = cpuHit && ($urandom_range(0, 1) == 1);
      cpuRd  = cpuHit && (!cpuWr || ($urandom_range(0, 1) == 1));
      cpuA   = 22'($urandom); cpuD = 8'($urandom);
      sdQ    = 16'($urandom);
      step();
      req[0] = iniReq; wr[0] = iniWr; a[0] = iniA; d[0] = iniD;
      req[1] = dlReq;  wr[1] = 1'b1;  a[1] = dlA;  d[1] = dlD;
      req[2] = cpuRd | cpuWr; wr[2] = cpuWr; a[2] = cpuA; d[2] = cpuD;
      eRf = 0; eRd = 0; eWr = 0; eA = '0; eD = '0;
      for (int i = 0; i < 3; i++) eAck[i] = 0;
      if (busyM && e == doneAt) begin
        busyM = 0;
        if (cur == 3) mRf = 0;
        else begin mPend[cur] = 0; eAck[cur] = 1; end
      end
      if (busyM && cur == 2 && !mWr[2] && e == sampleAt) mQ = sdQ[7:0];
      if (!busyM && e >= freeAt && ready && (mRf || mPend[0] || mPend[1] || mPend[2])) begin
        if (mRf) cur = 3;
        else if (mPend[0]) cur = 0;
        else if (mPend[1]) cur = 1;
        else cur = 2;
        busyM = 1; doneAt = e + OP; freeAt = e + OP + 1; sampleAt = e + RL;
        if (cur == 3) eRf = 1;
        else begin
          eA = {2'b00, mA[cur]};
          if (mWr[cur]) begin eWr = 1; eD = {8'h00, mD[cur]}; end
          else eRd = 1;
        end
      end
      if (e % RP == 0) mRf = 1;
      for (int i = 0; i < 3; i++) begin
        if (req[i]) begin
          if (mPend[i]) mOv = 1;
          else begin mPend[i] = 1; mWr[i] = wr[i]; mA[i] = a[i]; mD[i] = d[i]; end
        end
      end
      actD = eRd ? 16'h0000 : sdD;
      expV = {eRf, eRd, eWr, eA, eD, eAck[0], eAck[1], eAck[2], mQ, mOv};
      actV = {sdRf, sdRd, sdWr, sdA, actD, iniAck, dlAck, cpuAck, cpuQ, overrun};
      total++;
      if (actV !== expV) $display("FAIL random rate=%0d cycle=%0d: got %h required %h", rate, e, actV, expV);
      else passed++;
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    ready = 1'b0;
    clear_inputs();
    test_reset();
    test_ready_read();
    test_priority();
    test_refresh();
    test_overrun();
    test_reset_busy();
    test_back_to_back();
    test_random(2500, 4);
    test_random(1500, 30);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sdram_arb.md
SDRAM_ARB -- requirements
Module: sdram_arb

Interface
REQ-001 Parameters SHALL be: OP_CYCLES, default 8, SDRAM cycles one access or refresh occupies; RD_LAT, default 6, cycles from read strobe to valid sdQ, legal only when 1 <= RD_LAT < OP_CYCLES; RFSH_PERIOD, default 500, cycles between refresh requests.
REQ-002 clock  in  1  SDRAM-domain clock (clock64); one clock; all logic on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ready  in  1  SDRAM controller initialised; no grant is issued while low.
REQ-005 iniReq, iniWr  in  1,1  init-loader request strobe and write flag.
REQ-006 iniA, iniD  in  22,8  init-loader address and data.
REQ-007 dlReq  in  1  ROM-download write strobe (download is always a write).
REQ-008 dlA, dlD  in  22,8  ROM-download address and data.
REQ-009 cpuRd, cpuWr  in  1,1  CPU read and write strobes; both high counts as a write.
REQ-010 cpuA, cpuD  in  22,8  CPU address and data.
REQ-011 iniAck, dlAck, cpuAck  out  1 each  one-cycle completion pulses.
REQ-012 cpuQ  out  8  CPU read data, held until the next CPU read completes.
REQ-013 sdRf, sdRd, sdWr  out  1 each  one-cycle command strobes to the SDRAM controller.
REQ-014 sdA, sdD  out  24,16  command address {2'b00,A} and write data {8'h00,D}.
REQ-015 sdQ  in  16  SDRAM read data; only sdQ[7:0] is used.
REQ-016 overrun  out  1  sticky flag: a request was dropped.

Function
REQ-017 Request capture: a strobe sets that requester's pending flag and registers its address, data and rd/wr at the same edge.
REQ-018 A strobe arriving while that requester is already pending, with no ack on this edge, SHALL be dropped, leave the captured fields unchanged and set overrun.
REQ-019 A strobe arriving on the same edge as its requester's completion SHALL be captured as a new pending request.
REQ-020 Refresh timer: a down-counter reloads to RFSH_PERIOD-1 on reaching 0 and sets rfPend at that edge; it is not re-counted if rfPend is already set.
REQ-021 FSM states: IDLE and BUSY.
REQ-022 IDLE to BUSY: on an edge with ready=1 and any pending, grant in fixed priority rfPend > ini > dl > cpu.
REQ-023 On that edge: register the grant, clear cnt to 0, and drive exactly one strobe (sdRf, sdRd or sdWr) high for the following cycle only, with sdA and sdD valid for that cycle.
REQ-024 BUSY: cnt increments every edge; at the edge where cnt==OP_CYCLES-1 the FSM returns to IDLE, clears the granted pending flag and pulses the matching ack for one cycle (a refresh has no ack).
REQ-025 Granted reads: cpuQ <= sdQ[7:0] at the edge where cnt==RD_LAT-1 (RD_LAT cycles after the strobe cycle); init and download reads never occur.
REQ-026 The FSM SHALL spend at least one cycle in IDLE between grants, so strobes are spaced >= OP_CYCLES+1 cycles apart.
REQ-027 Minimum latency is OP_CYCLES+1 edges from request-capture edge to ack edge.
REQ-028 ready falling during BUSY does not abort the access; it only blocks further grants.
REQ-029 sdA and sdD SHALL be 0 whenever no strobe is high.
REQ-030 No combinational path from any input to any output.

Reset
REQ-031 On reset=1 at an edge: state IDLE; all pending flags, acks, strobes, sdA, sdD, cpuQ and overrun set to 0; cnt 0; refresh counter RFSH_PERIOD-1; rfPend 0.
REQ-032 Reset during BUSY SHALL abandon the access with no ack; requests strobed in the reset cycle are discarded.

Verification
REQ-033 Reset, ready=0, cpuRd with cpuA=22'h012345 -> no strobe; raise ready -> one-cycle sdRd with sdA=24'h012345; sdQ=16'h00C3 at RD_LAT -> cpuAck pulses OP_CYCLES edges after the grant, cpuQ=8'hC3.
REQ-034 iniReq, dlReq and cpuWr (cpuD=8'hA5) on the same edge -> grants in order ini, dl, cpu, strobes 9 cycles apart at default OP_CYCLES; CPU sdWr carries sdD=16'h00A5.
REQ-035 Idle bench, default params -> sdRf pulse every 500 cycles; refresh due on the same edge as a pending cpuRd -> sdRf issued first, sdRd 9 cycles later.
REQ-036 Two cpuRd strobes before cpuAck -> single sdRd using the first address, overrun=1 and remains 1 until reset.
REQ-037 reset asserted at cnt=3 of a dlReq write -> no dlAck, all outputs 0 next cycle; after release, no strobe until a new request.
REQ-038 cpuRd on the same edge as cpuAck of the previous read -> second read captured and granted after one IDLE cycle; overrun stays 0.
